mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It takes the ALU result, store data and control bits each cycle, performs word loads and stores against a local data memory with a configurable wait-state count, and registers the write-back bundle for the register-file stage. While a memory access is in progress it raises `stall_flag` so the execute stage and everything above it hold their outputs.

---
 rtl/mem_stage.sv | 134 +++++++++++++
 tb/tb_mem_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores against a local data memory with a fixed
// wait-state count, registered write-back bundle, and a stall towards the execute stage.
module mem_stage #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall_flag,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_error
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(MEM_LATENCY) + 1;
  localparam logic [CW-1:0] CntInit = CW'(MEM_LATENCY - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, sdata_q;
  logic [4:0]      rd_q;
  logic            is_load_q;
  logic            wb_valid_q, wb_reg_write_q, mem_error_q;
  logic [4:0]      wb_rd_q;
  logic [31:0]     wb_data_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            mem_op, illegal, legal_mem, retire;
  logic [AW-1:0]   word_idx;

  assign mem_op    = mem_read | mem_write;
  assign illegal   = mem_op && ((alu_result[1:0] != 2'b00) || (mem_read && mem_write));
  assign legal_mem = mem_op && !illegal;
  assign word_idx  = addr_q[AW+1:2];
  assign retire    = (state_q == StBusy) && (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_flag = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid && legal_mem) begin
          stall_flag = 1'b1;
          state_d    = StBusy;
          cnt_d      = CntInit;
        end
      end
      StBusy: begin
        stall_flag = (cnt_q != '0);
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Upstream must never see a stall while the pipeline is being reset.
    if (reset) stall_flag = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      addr_q         <= '0;
      sdata_q        <= '0;
      rd_q           <= '0;
      is_load_q      <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      mem_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      mem_error_q    <= 1'b0;
      if (state_q == StIdle) begin
        if (in_valid) begin
          if (illegal) begin
            wb_valid_q  <= 1'b1;
            wb_rd_q     <= rd;
            wb_data_q   <= alu_result;
            mem_error_q <= 1'b1;
          end else if (mem_op) begin
            addr_q    <= alu_result;
            sdata_q   <= store_data;
            rd_q      <= rd;
            is_load_q <= mem_read;
          end else begin
            wb_valid_q     <= 1'b1;
            wb_reg_write_q <= reg_write && (rd != 5'd0);
            wb_rd_q        <= rd;
            wb_data_q      <= alu_result;
          end
        end
      end else if (retire) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= rd_q;
        if (is_load_q) begin
          wb_data_q      <= mem[word_idx];
          wb_reg_write_q <= (rd_q != 5'd0);
        end else begin
          wb_data_q <= addr_q;
        end
      end
    end
  end

  // Memory contents survive reset; a reset during BUSY suppresses the pending store.
  always_ff @(posedge clk) begin
    if (!reset && retire && !is_load_q) mem[word_idx] <= sdata_q;
  end

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign mem_error    = mem_error_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: two instances (latency 2 and 1) checked every cycle against a
// per-cycle expectation timeline built from the stage's timing rules, plus literal spot checks.
module tb_mem_stage;

  localparam int N = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        iv0 = 0, mr0 = 0, mw0 = 0, rw0 = 0;
  logic [4:0]  rd0 = '0;
  logic [31:0] alu0 = '0, sd0 = '0;
  logic        st0, wv0, wrw0, err0;
  logic [4:0]  wrd0;
  logic [31:0] wd0;

  logic        iv1 = 0, mr1 = 0, mw1 = 0, rw1 = 0;
  logic [4:0]  rd1 = '0;
  logic [31:0] alu1 = '0, sd1 = '0;
  logic        st1, wv1, wrw1, err1;
  logic [4:0]  wrd1;
  logic [31:0] wd1;

  mem_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .mem_read(mr0), .mem_write(mw0),
    .reg_write(rw0), .rd(rd0), .alu_result(alu0), .store_data(sd0), .stall_flag(st0),
    .wb_valid(wv0), .wb_reg_write(wrw0), .wb_rd(wrd0), .wb_data(wd0), .mem_error(err0)
  );

  mem_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .mem_read(mr1), .mem_write(mw1),
    .reg_write(rw1), .rd(rd1), .alu_result(alu1), .store_data(sd1), .stall_flag(st1),
    .wb_valid(wv1), .wb_reg_write(wrw1), .wb_rd(wrd1), .wb_data(wd1), .mem_error(err1)
  );

  // Expected outputs per instance per cycle; unset cycles expect no stall and no write-back.
  bit          exp_stall    [2][N];
  bit          exp_wbv      [2][N];
  bit          exp_regw     [2][N];
  bit          exp_err      [2][N];
  bit          exp_chk_rd   [2][N];
  bit          exp_chk_data [2][N];
  logic [4:0]  exp_rd       [2][N];
  logic [31:0] exp_data     [2][N];
  logic [31:0] model_mem    [2][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, cyc, act, want);
    end
  endtask

  task automatic cmp(input int d, input logic st, input logic wv, input logic wrw,
                     input logic err, input logic [4:0] r, input logic [31:0] dat);
    chk("stall_flag", d, {31'b0, st}, {31'b0, exp_stall[d][cyc]});
    chk("wb_valid", d, {31'b0, wv}, {31'b0, exp_wbv[d][cyc]});
    chk("wb_reg_write", d, {31'b0, wrw}, {31'b0, exp_regw[d][cyc]});
    chk("mem_error", d, {31'b0, err}, {31'b0, exp_err[d][cyc]});
    if (exp_chk_rd[d][cyc]) chk("wb_rd", d, {27'b0, r}, {27'b0, exp_rd[d][cyc]});
    if (exp_chk_data[d][cyc]) chk("wb_data", d, dat, exp_data[d][cyc]);
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < N) begin
      cmp(0, st0, wv0, wrw0, err0, wrd0, wd0);
      cmp(1, st1, wv1, wrw1, err1, wrd1, wd1);
    end
  end

  task automatic sched(input int d, input int c, input bit v, input bit rw, input bit err,
                       input logic [4:0] r, input logic [31:0] dat, input bit chk_rd);
    exp_wbv[d][c]      = v;
    exp_regw[d][c]     = rw;
    exp_err[d][c]      = err;
    exp_rd[d][c]       = r;
    exp_chk_rd[d][c]   = chk_rd;
    exp_data[d][c]     = dat;
    exp_chk_data[d][c] = 1'b1;
  endtask

  task automatic drive(input int d, input logic v, input logic mr, input logic mw,
                       input logic rw, input logic [4:0] r, input logic [31:0] a,
                       input logic [31:0] s);
    if (d == 0) begin
      iv0 = v; mr0 = mr; mw0 = mw; rw0 = rw; rd0 = r; alu0 = a; sd0 = s;
    end else begin
      iv1 = v; mr1 = mr; mw1 = mw; rw1 = rw; rd1 = r; alu1 = a; sd1 = s;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
      drive(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    end
  endtask

  // Presents one instruction for as many cycles as the stage's timing rules require,
  // and records what the outputs must be. t = first presentation cycle.
  task automatic op(input int d, input logic mr, input logic mw, input logic rw,
                    input logic [4:0] r, input logic [31:0] a, input logic [31:0] s,
                    output int t);
    int lat, w, pres;
    bit memop, bad;
    lat   = (d == 0) ? 2 : 1;
    memop = mr || mw;
    bad   = memop && (((a % 4) != 0) || (mr && mw));
    w     = int'((a / 4) % 256);
    @(posedge clk); #1;
    t = cyc;
    drive(d, 1, mr, mw, rw, r, a, s);
    if (!memop) begin
      sched(d, t + 1, 1, rw && (r != 5'd0), 0, r, a, 1);
      pres = 1;
    end else if (bad) begin
      sched(d, t + 1, 1, 0, 1, r, a, 0);
      pres = 1;
    end else begin
      for (int k = 0; k < lat; k++) exp_stall[d][t+k] = 1'b1;
      if (mr) begin
        sched(d, t + lat + 1, 1, r != 5'd0, 0, r, model_mem[d][w], 1);
      end else begin
        sched(d, t + lat + 1, 1, 0, 0, r, a, 0);
        model_mem[d][w] = s;
      end
      pres = lat + 1;
    end
    repeat (pres - 1) @(posedge clk);
  endtask

  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) model_mem[d][i] = 32'h0;
      for (int c = 1; c <= 3; c++) sched(d, c, 0, 0, 0, 5'd0, 32'h0, 1);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // ALU pass-through, back to back
    op(0, 0, 0, 1, 5'd3, 32'h11, 32'h0, t);
    op(0, 0, 0, 1, 5'd0, 32'h22, 32'h0, t2);
    idle(1);
    at_cycle(t2 + 1);
    chk("lit_alu_data", 0, wd0, 32'h22);
    chk("lit_alu_regw_rd0", 0, {31'b0, wrw0}, 32'h0);

    // Store then load, latency 2
    op(0, 0, 1, 0, 5'd0, 32'h10, 32'h12345678, t);
    op(0, 1, 0, 0, 5'd5, 32'h10, 32'h0, t);
    idle(1);
    at_cycle(t + 3);
    chk("lit_load_valid", 0, {31'b0, wv0}, 32'h1);
    chk("lit_load_data", 0, wd0, 32'h12345678);
    chk("lit_load_rd", 0, {27'b0, wrd0}, 32'h5);

    // Address wrap-around
    op(0, 0, 1, 0, 5'd0, 32'h400, 32'hA5A5A5A5, t);
    op(0, 1, 0, 0, 5'd6, 32'h000, 32'h0, t);
    idle(1);
    at_cycle(t + 3);
    chk("lit_wrap_data", 0, wd0, 32'hA5A5A5A5);

    // Illegal ops: misaligned load, then read+write together
    op(0, 1, 0, 0, 5'd8, 32'h13, 32'h0, t);
    idle(1);
    at_cycle(t + 1);
    chk("lit_misaligned_err", 0, {31'b0, err0}, 32'h1);
    chk("lit_misaligned_regw", 0, {31'b0, wrw0}, 32'h0);
    op(0, 0, 1, 0, 5'd0, 32'h20, 32'h0BADF00D, t);
    op(0, 1, 1, 0, 5'd9, 32'h20, 32'hFFFFFFFF, t);
    idle(1);
    at_cycle(t + 1);
    chk("lit_rw_err", 0, {31'b0, err0}, 32'h1);
    chk("lit_rw_data", 0, wd0, 32'h20);
    op(0, 1, 0, 0, 5'd10, 32'h20, 32'h0, t);
    idle(1);
    at_cycle(t + 3);
    chk("lit_rw_mem_unchanged", 0, wd0, 32'h0BADF00D);

    // Reset in the first BUSY cycle aborts a store
    op(0, 0, 1, 0, 5'd0, 32'h40, 32'h0, t);
    idle(1);
    @(posedge clk); #1;
    t = cyc;
    drive(0, 1, 0, 1, 0, 5'd0, 32'h40, 32'hDEADBEEF);
    exp_stall[0][t] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) sched(d, t + 2, 0, 0, 0, 5'd0, 32'h0, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    op(0, 1, 0, 0, 5'd7, 32'h40, 32'h0, t);
    idle(1);
    at_cycle(t + 3);
    chk("lit_abort_load_valid", 0, {31'b0, wv0}, 32'h1);
    chk("lit_abort_load_data", 0, wd0, 32'h0);

    // Latency 1: load followed immediately by an ALU op
    op(1, 0, 1, 0, 5'd0, 32'h8, 32'h000055AA, t);
    op(1, 1, 0, 0, 5'd9, 32'h8, 32'h0, t);
    op(1, 0, 0, 1, 5'd4, 32'h77, 32'h0, t2);
    idle(1);
    at_cycle(t2 + 1);
    chk("lit_l1_alu_valid", 1, {31'b0, wv1}, 32'h1);
    chk("lit_l1_alu_data", 1, wd1, 32'h77);
    chk("lit_l1_alu_rd", 1, {27'b0, wrd1}, 32'h4);

    idle(3);
    at_cycle(cyc + 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
